// File: rtl/dsp_add_4simd_sched_if.sv
// Requester-side bundle of the 4-lane SIMD add scheduler.
// Optional rsp_ovf signal exists only when DSP_ADD_SCHED_OVF_EN is defined.
interface dsp_add_4simd_sched_if #(
  parameter int NREQ = 8
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [12*NREQ-1:0]   req_a;
  logic [12*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      rsp_valid;
  logic [12*NREQ-1:0]   rsp_sum;
`ifdef DSP_ADD_SCHED_OVF_EN
  logic [NREQ-1:0]      rsp_ovf;
`endif

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_sum
`ifdef DSP_ADD_SCHED_OVF_EN
    , input rsp_ovf
`endif
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_sum
`ifdef DSP_ADD_SCHED_OVF_EN
    , output rsp_ovf
`endif
  );
endinterface

// File: rtl/dsp_add_4simd_sched.sv
// Round-robin scheduler sharing one 4-lane SIMD 12-bit adder among NREQ requesters.
// Define DSP_ADD_SCHED_OVF_EN to add per-requester signed-overflow flags (rsp_ovf).
//
// state   | meaning
// IDLE    | no lanes staged, accepting requests
// COLLECT | some lanes staged, waiting for more or for the wait timer
// ISSUE   | staged word goes to the DSP, no accepts this cycle
module dsp_add_4simd_sched #(
  parameter int NREQ     = 8,
  parameter int LAT      = 0,
  parameter int WAIT_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  dsp_add_4simd_sched_if.slave  rq,
  output logic [95:0]           dsp_inputs,
  input  logic [47:0]           dsp_ap_return,
  output logic                  busy
);
  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            wait_q, wait_d;
  logic [TW-1:0]            rr_q, rr_d;
  logic [2:0]               nfill_q, nfill_d;
  logic [3:0][11:0]         lane_a_q, lane_a_d;
  logic [3:0][11:0]         lane_b_q, lane_b_d;
  logic [3:0][TW-1:0]       lane_tag_q, lane_tag_d;
  logic [3:0]               lane_vld;
  logic [NREQ-1:0]          held;
  logic [NREQ-1:0]          grant;
  int                       idx;

  // Tag pipeline: one stage per DSP cycle plus the sampling stage.
  logic [LAT:0]             tv_q;
  logic [LAT:0][3:0]        tm_q;
  logic [LAT:0][3:0][TW-1:0] tt_q;

  logic [NREQ-1:0]          rsp_valid_q;
  logic [12*NREQ-1:0]       rsp_sum_q;

  always_comb begin
    for (int k = 0; k < 4; k++) lane_vld[k] = (3'(k) < nfill_q);
  end

  // Grant scan: cyclic from rr, skipping requesters already holding a lane.
  always_comb begin
    grant      = '0;
    held       = '0;
    idx        = 0;
    nfill_d    = nfill_q;
    lane_a_d   = lane_a_q;
    lane_b_d   = lane_b_q;
    lane_tag_d = lane_tag_q;
    rr_d       = rr_q;
    for (int k = 0; k < 4; k++)
      if (lane_vld[k]) held[lane_tag_q[k]] = 1'b1;
    if (state_q == ISSUE) begin
      nfill_d    = '0;
      lane_a_d   = '0;
      lane_b_d   = '0;
      lane_tag_d = '0;
    end else if (ce) begin
      for (int i = 0; i < NREQ; i++) begin
        idx = (int'(rr_q) + i) % NREQ;
        if (rq.req_valid[idx] && !held[idx] && (nfill_d < 3'd4)) begin
          grant[idx]                 = 1'b1;
          lane_a_d[nfill_d[1:0]]     = rq.req_a[12*idx +: 12];
          lane_b_d[nfill_d[1:0]]     = rq.req_b[12*idx +: 12];
          lane_tag_d[nfill_d[1:0]]   = TW'(idx);
          nfill_d                    = nfill_d + 3'd1;
          rr_d                       = TW'((idx + 1) % NREQ);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (nfill_d != 3'd0) begin
          state_d = (nfill_d == 3'd4) ? ISSUE : COLLECT;
          wait_d  = '0;
        end
      end
      COLLECT: begin
        if ((nfill_d == 3'd4) || (wait_q == CW'(WAIT_MAX - 1))) state_d = ISSUE;
        else wait_d = wait_q + 1'b1;
      end
      ISSUE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef DSP_ADD_SCHED_OVF_EN
  logic [LAT:0][3:0] to_q;
  logic [3:0]        lane_ovf;
  logic [11:0]       ovf_sum;

  always_comb begin
    lane_ovf = '0;
    ovf_sum  = '0;
    for (int k = 0; k < 4; k++) begin
      ovf_sum     = lane_a_q[k] + lane_b_q[k];
      lane_ovf[k] = lane_vld[k] && (lane_a_q[k][11] == lane_b_q[k][11])
                    && (ovf_sum[11] != lane_a_q[k][11]);
    end
  end

  logic [NREQ-1:0] rsp_ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_q      <= '0;
      rsp_ovf_q <= '0;
    end else if (ce) begin
      to_q[0] <= (state_q == ISSUE) ? lane_ovf : 4'b0;
      for (int j = 1; j <= LAT; j++) to_q[j] <= to_q[j-1];
      rsp_ovf_q <= '0;
      if (tv_q[LAT])
        for (int k = 0; k < 4; k++)
          if (tm_q[LAT][k]) rsp_ovf_q[tt_q[LAT][k]] <= to_q[LAT][k];
    end
  end

  assign rq.rsp_ovf = rsp_ovf_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      rr_q        <= '0;
      nfill_q     <= '0;
      lane_a_q    <= '0;
      lane_b_q    <= '0;
      lane_tag_q  <= '0;
      dsp_inputs  <= '0;
      tv_q        <= '0;
      tm_q        <= '0;
      tt_q        <= '0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
    end else if (ce) begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rr_q       <= rr_d;
      nfill_q    <= nfill_d;
      lane_a_q   <= lane_a_d;
      lane_b_q   <= lane_b_d;
      lane_tag_q <= lane_tag_d;
      if (state_q == ISSUE) begin
        for (int k = 0; k < 4; k++) dsp_inputs[24*k +: 24] <= {lane_b_q[k], lane_a_q[k]};
        tv_q[0] <= 1'b1;
        tm_q[0] <= lane_vld;
        tt_q[0] <= lane_tag_q;
      end else begin
        tv_q[0] <= 1'b0;
        tm_q[0] <= '0;
        tt_q[0] <= '0;
      end
      for (int j = 1; j <= LAT; j++) begin
        tv_q[j] <= tv_q[j-1];
        tm_q[j] <= tm_q[j-1];
        tt_q[j] <= tt_q[j-1];
      end
      // Result lane 0 sits in the DSP's most significant bits.
      rsp_valid_q <= '0;
      if (tv_q[LAT])
        for (int k = 0; k < 4; k++)
          if (tm_q[LAT][k]) begin
            rsp_valid_q[tt_q[LAT][k]]              <= 1'b1;
            rsp_sum_q[12*int'(tt_q[LAT][k]) +: 12] <= dsp_ap_return[47-12*k -: 12];
          end
    end
  end

  assign rq.req_ready = grant;
  assign rq.rsp_valid = rsp_valid_q;
  assign rq.rsp_sum   = rsp_sum_q;
  assign busy = (state_q != IDLE) | (|tv_q) | (|rsp_valid_q);
endmodule

// File: tb/tb_dsp_add_4simd_sched.sv
// Self-checking bench for dsp_add_4simd_sched with a combinational SIMD adder model.
// Checks rsp_ovf as well when DSP_ADD_SCHED_OVF_EN is defined.
module tb_dsp_add_4simd_sched;
  localparam int NREQ = 8;
  localparam int LAT = 0;
  localparam int WAIT_MAX = 3;

  typedef logic [12:0] exp_t;
  typedef struct {
    logic [7:0]  m;
    logic [11:0] a;
    logic [11:0] b;
    logic [7:0]  r;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [95:0] dsp_inputs;
  logic [47:0] dsp_ap_return;
  logic        busy;
  logic        ce_seen = 1'b0;
  logic [7:0]  last_ready;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q [NREQ][$];
  vec_t        vecs [5];

  dsp_add_4simd_sched_if #(.NREQ(NREQ)) rq ();

  dsp_add_4simd_sched #(.NREQ(NREQ), .LAT(LAT), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .ce(ce), .rq(rq),
    .dsp_inputs(dsp_inputs), .dsp_ap_return(dsp_ap_return), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    dsp_ap_return = '0;
    for (int k = 0; k < 4; k++)
      dsp_ap_return[47-12*k -: 12] = dsp_inputs[24*k +: 12] + dsp_inputs[24*k+12 +: 12];
  end

  always @(posedge clk) ce_seen <= ce;

  function automatic exp_t model(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] s;
    s = a + b;
    return {(a[11] == b[11]) && (s[11] != a[11]), s};
  endfunction

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  // Scoreboard pop on every fresh response pulse.
  always @(negedge clk) begin
    if (rst && ce_seen) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rq.rsp_valid[i]) begin
          exp_t e, got;
          checks++;
          if (exp_q[i].size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected req%0d got sum %h required no response", i, rq.rsp_sum[12*i +: 12]);
          end else begin
            e = exp_q[i].pop_front();
`ifdef DSP_ADD_SCHED_OVF_EN
            got = {rq.rsp_ovf[i], rq.rsp_sum[12*i +: 12]};
`else
            got = {e[12], rq.rsp_sum[12*i +: 12]};
`endif
            if (got !== e) begin
              errors++;
              $display("FAIL rsp_req%0d got %h required %h", i, got, e);
            end
          end
        end
      end
    end
  end

  task automatic set_req(input logic [7:0] m, input logic [11:0] a0, input logic [11:0] b0);
    for (int i = 0; i < NREQ; i++) begin
      rq.req_valid[i]        = m[i];
      rq.req_a[12*i +: 12]   = a0 + 12'(i);
      rq.req_b[12*i +: 12]   = b0;
    end
  endtask

  task automatic accept_and_tick();
    #1;
    last_ready = rq.req_ready;
    for (int i = 0; i < NREQ; i++)
      if (rq.req_valid[i] && rq.req_ready[i] && ce && rst)
        exp_q[i].push_back(model(rq.req_a[12*i +: 12], rq.req_b[12*i +: 12]));
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout busy got 1 required 0");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] exp_word;
    int n;
    vecs[0] = '{m: 8'h20, a: 12'hFF6, b: 12'h003, r: 8'h20};
    vecs[1] = '{m: 8'h81, a: 12'h7FF, b: 12'h001, r: 8'h81};
    vecs[2] = '{m: 8'h3C, a: 12'h100, b: 12'hF00, r: 8'h3C};
    vecs[3] = '{m: 8'hC0, a: 12'h800, b: 12'h800, r: 8'hC0};
    vecs[4] = '{m: 8'h11, a: 12'h000, b: 12'h000, r: 8'h11};

    rst = 1'b1;
    ce  = 1'b0;
    set_req(8'h00, 12'h0, 12'h0);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_dsp_inputs", dsp_inputs, 96'h0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rsp_valid", rq.rsp_valid, 8'h0);
    chk("reset_rsp_sum", rq.rsp_sum, 96'h0);
    rst = 1'b1;
    ce  = 1'b1;
    @(negedge clk);

    // Full batch: four lanes in one cycle, response two cycles after ISSUE.
    set_req(8'h0F, 12'd1, 12'd10);
    accept_and_tick();
    chk("full_ready", last_ready, 8'h0F);
    set_req(8'h0F, 12'h500, 12'h000);
    accept_and_tick();
    chk("issue_ready", last_ready, 8'h00);
    set_req(8'h00, 12'h0, 12'h0);
    exp_word = '0;
    for (int k = 0; k < 4; k++) exp_word[24*k +: 24] = {12'd10, 12'(k + 1)};
    chk("full_dsp_inputs", dsp_inputs, exp_word);
    chk("full_no_early_rsp", rq.rsp_valid, 8'h00);
    @(negedge clk);
    chk("full_rsp_valid", rq.rsp_valid, 8'h0F);
    chk("full_rsp_sum", rq.rsp_sum[47:0], {12'd14, 12'd13, 12'd12, 12'd11});
    wait_idle();

    // Timeout: one requester, three COLLECT cycles then ISSUE.
    set_req(8'h20, 12'hFF6, 12'h003);
    accept_and_tick();
    chk("timeout_ready", last_ready, 8'h20);
    set_req(8'h00, 12'h0, 12'h0);
    repeat (3) @(negedge clk);
    chk("timeout_not_issued", dsp_inputs, exp_word);
    @(negedge clk);
    chk("timeout_dsp_inputs", dsp_inputs, {72'h0, 12'h003, 12'hFFB});
    chk("timeout_no_early_rsp", rq.rsp_valid, 8'h00);
    @(negedge clk);
    chk("timeout_rsp_valid", rq.rsp_valid, 8'h20);
    chk("timeout_rsp_sum", rq.rsp_sum[71:60], 12'hFFE);
    wait_idle();

    for (int v = 0; v < 5; v++) begin
      set_req(vecs[v].m, vecs[v].a, vecs[v].b);
      accept_and_tick();
      chk($sformatf("vec%0d_ready", v), last_ready, vecs[v].r);
      set_req(8'h00, 12'h0, 12'h0);
      wait_idle();
    end

    // Reset mid-batch: staged requests must vanish.
    set_req(8'h06, 12'h123, 12'h321);
    accept_and_tick();
    set_req(8'h00, 12'h0, 12'h0);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) exp_q[i].delete();
    #1;
    chk("midrst_dsp_inputs", dsp_inputs, 96'h0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rsp_valid", rq.rsp_valid, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_stays_idle", busy, 1'b0);

    // Round robin with all requesters held valid.
    for (int j = 0; j < 5; j++) begin
      logic [7:0] rr_exp [5];
      rr_exp = '{8'h0F, 8'h00, 8'hF0, 8'h00, 8'h0F};
      set_req(8'hFF, 12'h010 + 12'(j * 16), 12'h020);
      accept_and_tick();
      chk($sformatf("rr_ready%0d", j), last_ready, rr_exp[j]);
    end
    set_req(8'h00, 12'h0, 12'h0);
    wait_idle();

    // ce stall between ISSUE and response.
    set_req(8'h0F, 12'h7F0, 12'h00A);
    accept_and_tick();
    ce = 1'b0;
    set_req(8'h10, 12'h001, 12'h001);
    accept_and_tick();
    chk("stall_ready", last_ready, 8'h00);
    set_req(8'h00, 12'h0, 12'h0);
    repeat (4) @(negedge clk);
    chk("stall_rsp_frozen", rq.rsp_valid, 8'h00);
    chk("stall_busy", busy, 1'b1);
    ce = 1'b1;
    @(negedge clk);
    exp_word = '0;
    for (int k = 0; k < 4; k++) exp_word[24*k +: 24] = {12'h00A, 12'h7F0 + 12'(k)};
    chk("stall_dsp_inputs", dsp_inputs, exp_word);
    chk("stall_no_early_rsp", rq.rsp_valid, 8'h00);
    @(negedge clk);
    chk("stall_rsp_valid", rq.rsp_valid, 8'h0F);
    ce = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall_rsp_held", rq.rsp_valid, 8'h0F);
    ce = 1'b1;
    @(negedge clk);
    chk("stall_rsp_cleared", rq.rsp_valid, 8'h00);
    wait_idle();

    // Signed wrap: 2047 + 1.
    set_req(8'h01, 12'h7FF, 12'h001);
    accept_and_tick();
    set_req(8'h00, 12'h0, 12'h0);
    n = 0;
    while (!rq.rsp_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_rsp_seen", rq.rsp_valid[0], 1'b1);
    chk("wrap_rsp_sum", rq.rsp_sum[11:0], 12'h800);
`ifdef DSP_ADD_SCHED_OVF_EN
    chk("wrap_rsp_ovf", rq.rsp_ovf[0], 1'b1);
`endif
    wait_idle();

    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL missing_rsp req%0d got %0d pending required 0", i, exp_q[i].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dsp_add_4simd_sched.md
Name: dsp_add_4simd_sched

Overview:
Round-robin scheduler that shares one 4-lane SIMD 12-bit adder DSP (96-bit packed operand word, 48-bit packed result) among NREQ scalar add requesters. It collects up to 4 requests into lane staging registers and issues a packed word when all lanes are full or a wait timer expires. It then routes each lane result back to its originating requester. It sits between the HLS-generated requester logic and the SIMD adder instance.

Parameters:
NREQ, 8, number of requesters (2..16)
LAT, 0, DSP pipeline latency in cycles from dsp_inputs to dsp_ap_return (0 = combinational)
WAIT_MAX, 3, max cycles a partially filled batch waits before forced issue (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
ce  in  1  clock enable; also drives DSP ce
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; handshake = valid & ready
req_a  in  12*NREQ  operand a, requester i at [12i+11:12i], signed
req_b  in  12*NREQ  operand b, same packing
dsp_inputs  out  96  packed operands to DSP, registered
dsp_ap_return  in  48  packed DSP sums
rsp_valid  out  NREQ  one-cycle result pulse per requester
rsp_sum  out  12*NREQ  result, requester i at [12i+11:12i]
busy  out  1  high when any lane is staged or any batch is in flight

Behaviour:
- Reset (rst=0, async): state IDLE, lanes empty, wait counter 0, rr pointer 0, dsp_inputs 0, rsp_valid 0, rsp_sum 0, tag pipeline cleared. In-flight batches are discarded; no rsp_valid for them.
- Lane packing: lane k a -> dsp_inputs[24k+11:24k], b -> [24k+23:24k+12]. Result lane k <- dsp_ap_return[47-12k:36-12k], so lane0 maps to the MSBs. Empty lanes drive a=b=0.
- Arithmetic: 12-bit two's-complement wrap; no widening.
- FSM:
  - IDLE: no lanes filled. Accepts are allowed. Any accept -> COLLECT; if the accept fills 4 lanes -> ISSUE.
  - COLLECT: wait counter increments each ce cycle. Move to ISSUE when 4 lanes are filled or counter reaches WAIT_MAX-1. The counter resets on entry to COLLECT.
  - ISSUE: one cycle. req_ready is all 0. dsp_inputs <= staged word. The lane-to-requester tag plus lane-valid mask enters a LAT+1 deep tag pipeline. Lanes are cleared. Next state is IDLE.
- Grant: in IDLE/COLLECT with ce=1, scan requesters cyclically starting at rr. Grant valid requesters not already holding a lane in this batch, up to the free-lane count. Fill lanes in ascending order. rr <= (last granted index + 1) mod NREQ; unchanged if nothing is granted. req_ready is combinational from req_valid, the lane state and rr.
- Timing: issue register update at edge T. dsp_inputs is valid from T. dsp_ap_return is sampled at edge T+1+LAT. rsp_valid[i] and rsp_sum lane are registered and visible for one cycle after that edge. Total from accept-complete (ISSUE) to rsp_valid is LAT+2 cycles.
- Ordering: a requester may re-request before its response. Responses per requester are returned in request order. A requester holds at most one lane per batch.
- ce=0: all registers hold (FSM, counter, rr, lanes, tag pipeline, rsp_valid, rsp_sum). req_ready is forced to 0. A pending rsp_valid pulse stays high until the next ce=1 edge.
- Responses have no backpressure; requesters must always sink rsp_valid.
- busy = (state != IDLE) | any tag pipeline stage valid | any rsp_valid.

Optional Feature:
Macro DSP_ADD_SCHED_OVF_EN.
- Defined: adds output rsp_ovf (NREQ). rsp_ovf[i] pulses with rsp_valid[i] when the lane's signed add overflowed (operands same sign, result sign differs). The overflow is computed from staged operands and carried through the tag pipeline.
- Undefined: no port, no extra logic.

Test Plan:
- Reset mid-batch: stage 2 lanes, assert rst=0 -> dsp_inputs=0, busy=0, no rsp_valid ever for those requests.
- Full batch, LAT=0: req 0..3 valid with a=i+1, b=10, all same cycle -> all ready. Next cycle dsp_inputs lane k = {10, k+1}. rsp_sum = 11,12,13,14 with rsp_valid[3:0]=1111 two cycles after ISSUE.
- Timeout: only req5 valid (a=-5, b=3), WAIT_MAX=3 -> issue after 3 COLLECT cycles, lanes1-3 zero. rsp_sum5 = 0xFFE (-2).
- Round-robin fairness: all 8 requesters held valid -> batches grant {0,1,2,3}, {4,5,6,7}, {0,1,2,3}. No requester is starved.
- ce stall: drop ce for 5 cycles during ISSUE->response -> outputs frozen. rsp_valid appears exactly LAT+2 ce-active cycles after ISSUE.
- Wrap/overflow (OVF_EN): a=2047, b=1 -> rsp_sum=0x800 (-2048), rsp_ovf=1. Without the macro, same sum and no port.
